alu_ctrl_mdu: RTL and testbench
===============================

Name: alu_ctrl_mdu

Overview:
Second-generation ALU control for the multi-cycle MIPS datapath. It decodes ALUop/Func into a wider, registered ALU operation code that is backward compatible with the existing 3-bit codes. It adds an iterative multiply/divide sequencer with HI/LO registers and a start/busy/done handshake. The main control FSM stalls on md_busy.

Parameters:
WIDTH, 32, operand/HI/LO width; iterative core takes WIDTH steps
OPW, 4, width of ALUoper (must be at least 4)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
ALUop  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type via Func, 11 slt (slti)
Func  in  6  instruction funct field
dec_en  in  1  latch decode of ALUop/Func (decode state of main FSM)
ALUoper  out  OPW  registered ALU operation code
hilo_rd  out  2  registered; 01 = mfhi, 10 = mflo, 00 = none
md_op  out  1  registered; latched Func is mult/multu/div/divu with ALUop=10
md_start  in  1  start pulse for multiply/divide
src_a  in  WIDTH  rs operand, sampled on accepted md_start
src_b  in  WIDTH  rt operand, sampled on accepted md_start
md_busy  out  1  sequencer running
md_done  out  1  one-cycle completion pulse
div_by_zero  out  1  valid with md_done; divide had src_b = 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: ALUoper=2 (add); hilo_rd=0; md_op=0; md_busy=0; md_done=0; div_by_zero=0; hi=0; lo=0; FSM=IDLE. Reset mid-operation aborts the operation and discards partial results.
- ALUoper codes: 0 and, 1 or, 2 add, 3 xor, 4 nor, 5 sll, 6 sub, 7 slt, 8 sltu, 9 srl, 10 sra, 15 nop. Codes 0/1/2/6/7 match the legacy 3-bit encoding.
- Decode with ALUop=10 (Func to code):
  - 100000/100001 add
  - 100010/100011 sub
  - 100100 and; 100101 or; 100110 xor; 100111 nor
  - 101010 slt; 101011 sltu
  - 000000 sll; 000010 srl; 000011 sra
  - 010000 mfhi: ALUoper=15, hilo_rd=01
  - 010010 mflo: ALUoper=15, hilo_rd=10
  - 0110xx (mult/multu/div/divu): ALUoper=15, md_op=1
  - any other funct: 15
- Decode with other ALUop values: ALUop 00 gives 2, 01 gives 6, 11 gives 7; hilo_rd=0 and md_op=0.
- Decode latency: outputs update on the edge where dec_en=1. They hold otherwise.
- md_start is accepted only when md_op=1 and FSM=IDLE. Otherwise it is ignored, with no state change. Accepting it latches the funct's low 2 bits: 00 mult, 01 multu, 10 div, 11 divu.
- FSM IDLE -> CALC -> FIX -> IDLE:
  - IDLE, accepted start: signed ops store |src_a| and |src_b| plus sign bits; unsigned ops store raw values; iteration count=0; go to CALC. A divide with src_b=0 goes directly to FIX with the dz flag set.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. After exactly WIDTH steps go to FIX.
  - FIX: signed multiply negates the 2*WIDTH product if sign_a^sign_b. Signed divide negates the quotient if sign_a^sign_b and the remainder if sign_a. Multiply writes {hi,lo}=product; divide writes lo=quotient, hi=remainder. Divide-by-zero leaves hi/lo unchanged. Then go to IDLE.
- Handshake timing: md_busy=1 in CALC and FIX. md_done=1 for exactly the one cycle after FIX, the same edge at which the new hi/lo become visible. div_by_zero pulses with md_done and is otherwise 0.
- Latency: md_done goes high WIDTH+2 edges after the accepting edge. For divide-by-zero it goes high 2 edges after.
- Overflow cases: most-negative / -1 gives lo=most-negative, hi=0, with no flag (natural wrap).
- dec_en while busy: the decode outputs update, but the running operation is unaffected. md_start during md_done cycle is accepted (FSM already IDLE).

Decomposition:
- Shared include alu_defs.vh: ALUoper code constants, funct constants, ALUop encodings, FSM state encodings.
- One sub-module, md_iter: the CALC/FIX datapath, iteration counter and sign fix-up, parametrised by WIDTH.
- Top level holds the decode registers, the start qualification, and hi/lo.

Test Plan:
- Decode sweep: dec_en with ALUop=10 for every listed funct, plus ALUop 00/01/11 -> codes as tabled; undefined funct 111111 -> 15; legacy functs give legacy codes.
- multu: src_a=0xFFFFFFFF, src_b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE; md_done exactly 34 edges after start; busy for 33 cycles.
- mult: src_a=-7 (0xFFFFFFF9), src_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- div: src_a=-7, src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2.
- div by zero: hi/lo preloaded to 5/9, div with src_b=0 -> md_done after 2 edges, div_by_zero=1, hi=5, lo=9 unchanged.
- Robustness: md_start while busy ignored (result unchanged); md_start with md_op=0 ignored; rst asserted mid-CALC -> next cycle busy=0, hi=lo=0, ALUoper=2.

Source files
------------

// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared definitions for the ALU control / multiply-divide block.
// Holds the ALUoper codes, funct codes, ALUop encodings, HI/LO select and
// sequencer state encodings, plus the combinational ALUop/Func decoder.
package alu_ctrl_mdu_pkg;

  // ALUoper codes; 0/1/2/6/7 keep the legacy 3-bit meaning
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_NOP  = 4'd15;

  // ALUop encodings from the main control FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_SLT   = 2'b11;

  // funct field values
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  // mult/multu/div/divu share the upper four funct bits
  localparam logic [3:0] FN_MD_HI4 = 4'b0110;

  // multiply/divide sub-op, taken from funct[1:0]
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // hilo_rd select
  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  typedef struct packed {
    logic [3:0] oper;
    logic [1:0] hilo;
    logic       md_op;
  } dec_t;

  function automatic dec_t decode(input logic [1:0] aluop, input logic [5:0] func);
    dec_t d;
    d.oper  = OP_NOP;
    d.hilo  = HILO_NONE;
    d.md_op = 1'b0;
    case (aluop)
      ALUOP_ADD: d.oper = OP_ADD;
      ALUOP_SUB: d.oper = OP_SUB;
      ALUOP_SLT: d.oper = OP_SLT;
      default: begin
        if (func[5:2] == FN_MD_HI4) begin
          d.md_op = 1'b1;
        end else begin
          case (func)
            FN_ADD, FN_ADDU: d.oper = OP_ADD;
            FN_SUB, FN_SUBU: d.oper = OP_SUB;
            FN_AND:          d.oper = OP_AND;
            FN_OR:           d.oper = OP_OR;
            FN_XOR:          d.oper = OP_XOR;
            FN_NOR:          d.oper = OP_NOR;
            FN_SLT:          d.oper = OP_SLT;
            FN_SLTU:         d.oper = OP_SLTU;
            FN_SLL:          d.oper = OP_SLL;
            FN_SRL:          d.oper = OP_SRL;
            FN_SRA:          d.oper = OP_SRA;
            FN_MFHI:         d.hilo = HILO_HI;
            FN_MFLO:         d.hilo = HILO_LO;
            default:         d.oper = OP_NOP;
          endcase
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_mdu_md_iter.sv
// Iterative multiply/divide datapath: IDLE -> CALC (WIDTH steps) -> FIX -> IDLE.
// Latency: done_o rises WIDTH+1 edges after the start edge (1 edge for divide-by-zero).
// Backpressure: none; start_i must only be raised while busy_o=0 (qualified by the parent).
// Ports: clk/rst; start_i, op_i (funct[1:0]), a_i/b_i operands; busy_o, done_o, dz_o
// pulse flags; wr_o with hi_o/lo_o is the one-cycle result write during FIX.
module md_iter
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dz_o,
  output logic             wr_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // multiply: {partial product upper, multiplier being shifted out}
  // divide:   {partial remainder, dividend shifting into quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;   // |multiplicand| or |divisor|
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic               dzout_q, dzout_d;

  logic               in_signed, neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] step_nxt;
  logic               fix_signed, fix_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes; signed ops are funct[0]=0
  always_comb begin
    in_signed = ~op_i[0];
    neg_a     = in_signed & a_i[WIDTH-1];
    neg_b     = in_signed & b_i[WIDTH-1];
    mag_a     = neg_a ? -a_i : a_i;
    mag_b     = neg_b ? -b_i : b_i;
  end

  // One iteration step for either operation
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_sh  = {acc_q, 1'b0};
    div_ge  = div_sh[2*WIDTH:WIDTH] >= {1'b0, opb_q};
    // remainder always fits WIDTH bits after a successful subtract
    div_sub = div_sh[2*WIDTH-1:WIDTH] - opb_q;
    if (op_q[1]) begin
      step_nxt = div_ge ? {div_sub, div_sh[WIDTH-1:1], 1'b1} : div_sh[2*WIDTH-1:0];
    end else begin
      step_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the unsigned magnitude result
  always_comb begin
    fix_signed = ~op_q[0];
    fix_div    = op_q[1];
    prod_fix   = (fix_signed & (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo_fix    = (fix_signed & (sa_q ^ sb_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix    = (fix_signed & sa_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    hi_o       = fix_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    lo_o       = fix_div ? quo_fix : prod_fix[WIDTH-1:0];
    wr_o       = (state_q == MD_FIX) & ~dz_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    dzout_d = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          sa_d  = neg_a;
          sb_d  = neg_b;
          cnt_d = '0;
          acc_d = {{WIDTH{1'b0}}, mag_a};
          opb_d = mag_b;
          if (op_i[1] && (b_i == '0)) begin
            dz_d    = 1'b1;
            state_d = MD_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        acc_d = step_nxt;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = MD_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      MD_FIX: begin
        done_d  = 1'b1;
        dzout_d = dz_q;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
      dzout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
      dzout_q <= dzout_d;
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = done_q;
  assign dz_o   = dzout_q;

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control with registered wide op decode plus iterative multiply/divide and HI/LO.
// Latency: decode 1 edge after dec_en; md_done WIDTH+2 edges counting the accepting edge.
// Backpressure: md_start ignored unless md_op=1 and sequencer idle; main FSM stalls on md_busy.
// Ports: clk/rst; ALUop, Func, dec_en decode inputs; ALUoper, hilo_rd, md_op decode outputs;
// md_start, src_a, src_b start request; md_busy, md_done, div_by_zero status; hi, lo results.
module alu_ctrl_mdu
  import alu_ctrl_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       Func,
  input  logic             dec_en,
  output logic [OPW-1:0]   ALUoper,
  output logic [1:0]       hilo_rd,
  output logic             md_op,
  input  logic             md_start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             md_busy,
  output logic             md_done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  dec_t             dec;
  logic [OPW-1:0]   aluoper_q, aluoper_d;
  logic [1:0]       hilo_q, hilo_d;
  logic             md_op_q, md_op_d;
  logic [1:0]       mdfn_q, mdfn_d;   // funct[1:0] captured with the decode
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             md_accept;
  logic             md_wr;
  logic [WIDTH-1:0] md_hi, md_lo;

  // FSM idle is equivalent to busy low, including the md_done cycle
  assign md_accept = md_start & md_op_q & ~md_busy;

  md_iter #(.WIDTH(WIDTH)) u_md_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_accept),
    .op_i    (mdfn_q),
    .a_i     (src_a),
    .b_i     (src_b),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .dz_o    (div_by_zero),
    .wr_o    (md_wr),
    .hi_o    (md_hi),
    .lo_o    (md_lo)
  );

  always_comb begin
    dec       = decode(ALUop, Func);
    aluoper_d = aluoper_q;
    hilo_d    = hilo_q;
    md_op_d   = md_op_q;
    mdfn_d    = mdfn_q;
    if (dec_en) begin
      aluoper_d = OPW'(dec.oper);
      hilo_d    = dec.hilo;
      md_op_d   = dec.md_op;
      mdfn_d    = Func[1:0];
    end
    hi_d = hi_q;
    lo_d = lo_q;
    // results land on the same edge that raises md_done
    if (md_wr) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluoper_q <= OPW'(OP_ADD);
      hilo_q    <= HILO_NONE;
      md_op_q   <= 1'b0;
      mdfn_q    <= MD_MULT;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      aluoper_q <= aluoper_d;
      hilo_q    <= hilo_d;
      md_op_q   <= md_op_d;
      mdfn_q    <= mdfn_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign ALUoper = aluoper_q;
  assign hilo_rd = hilo_q;
  assign md_op   = md_op_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    ALUop = 2'b00;
  logic [5:0]    Func = 6'b0;
  logic          dec_en = 1'b0;
  logic [3:0]    ALUoper;
  logic [1:0]    hilo_rd;
  logic          md_op;
  logic          md_start = 1'b0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          md_busy;
  logic          md_done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  always #5 clk = ~clk;

  alu_ctrl_mdu #(.WIDTH(W), .OPW(4)) dut (
    .clk(clk), .rst(rst), .ALUop(ALUop), .Func(Func), .dec_en(dec_en),
    .ALUoper(ALUoper), .hilo_rd(hilo_rd), .md_op(md_op), .md_start(md_start),
    .src_a(src_a), .src_b(src_b), .md_busy(md_busy), .md_done(md_done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [3:0]  m_oper;
  logic [1:0]  m_hilo;
  logic        m_mdop;
  logic [1:0]  m_fn;
  int          m_left;          // cycles of busy remaining
  logic        m_pdz;
  logic [31:0] m_phi, m_plo;    // pending result
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz;
  logic        m_idle, t_dz;
  logic [31:0] t_hi, t_lo;

  // decode table: {oper, hilo, md_op}
  function automatic logic [6:0] ref_decode(input logic [1:0] aluop, input logic [5:0] fn);
    if (aluop == 2'b00) return {4'd2, 2'b00, 1'b0};
    if (aluop == 2'b01) return {4'd6, 2'b00, 1'b0};
    if (aluop == 2'b11) return {4'd7, 2'b00, 1'b0};
    if (fn inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}) return {4'd15, 2'b00, 1'b1};
    case (fn)
      6'b100000, 6'b100001: return {4'd2, 2'b00, 1'b0};
      6'b100010, 6'b100011: return {4'd6, 2'b00, 1'b0};
      6'b100100: return {4'd0, 2'b00, 1'b0};
      6'b100101: return {4'd1, 2'b00, 1'b0};
      6'b100110: return {4'd3, 2'b00, 1'b0};
      6'b100111: return {4'd4, 2'b00, 1'b0};
      6'b101010: return {4'd7, 2'b00, 1'b0};
      6'b101011: return {4'd8, 2'b00, 1'b0};
      6'b000000: return {4'd5, 2'b00, 1'b0};
      6'b000010: return {4'd9, 2'b00, 1'b0};
      6'b000011: return {4'd10, 2'b00, 1'b0};
      6'b010000: return {4'd15, 2'b01, 1'b0};
      6'b010010: return {4'd15, 2'b10, 1'b0};
      default:   return {4'd15, 2'b00, 1'b0};
    endcase
  endfunction

  task automatic ref_md(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic dz, output logic [31:0] rhi, output logic [31:0] rlo);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0; rhi = '0; rlo = '0;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (fn)
      2'b00: begin p = sa * sb; rhi = p[63:32]; rlo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; rhi = p[63:32]; rlo = p[31:0]; end
      2'b10: begin
        if (b == 0) dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; rlo = q[31:0]; rhi = r[31:0]; end
      end
      default: begin
        if (b == 0) dz = 1'b1;
        else begin rlo = a / b; rhi = a % b; end
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_oper = 4'd2; m_hilo = 2'b00; m_mdop = 1'b0; m_fn = 2'b00;
      m_left = 0; m_pdz = 1'b0; m_phi = '0; m_plo = '0;
      m_hi = '0; m_lo = '0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_idle = (m_left == 0);
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_dz   = m_pdz;
          if (!m_pdz) begin m_hi = m_phi; m_lo = m_plo; end
        end
      end
      if (md_start && m_mdop && m_idle) begin
        ref_md(m_fn, src_a, src_b, t_dz, t_hi, t_lo);
        m_pdz = t_dz; m_phi = t_hi; m_plo = t_lo;
        m_left = t_dz ? 1 : W + 1;
      end
      if (dec_en) begin
        {m_oper, m_hilo, m_mdop} = ref_decode(ALUop, Func);
        m_fn = Func[1:0];
      end
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_ALUoper", ALUoper, m_oper);
      chk("cyc_hilo_rd", hilo_rd, m_hilo);
      chk("cyc_md_op", md_op, m_mdop);
      chk("cyc_md_busy", md_busy, m_left > 0);
      chk("cyc_md_done", md_done, m_done);
      chk("cyc_div_by_zero", div_by_zero, m_dz);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers (start and end just after a negedge) ----------------
  task automatic dec(input logic [1:0] op, input logic [5:0] fn);
    ALUop = op; Func = fn; dec_en = 1'b1;
    @(negedge clk);
    dec_en = 1'b0;
  endtask

  // edges counts the accepting edge as 1
  task automatic wait_done(input int maxc, output int edges, output int busyc);
    edges = 0; busyc = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      md_start = 1'b0;
      edges++;
      if (md_busy) busyc++;
      if (md_done) break;
    end
    chk("done_seen", md_done, 1'b1);
  endtask

  task automatic run_md(input logic [31:0] a, input logic [31:0] b, output int edges, output int busyc);
    src_a = a; src_b = b; md_start = 1'b1;
    wait_done(60, edges, busyc);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] sweep [0:19];
  int e, bc;

  initial begin
    sweep = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
              6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
              6'b000011, 6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010,
              6'b011011, 6'b111111};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // reset state
    chk("rst_ALUoper", ALUoper, 4'd2);
    chk("rst_hilo_rd", hilo_rd, 2'b00);
    chk("rst_md_op", md_op, 1'b0);
    chk("rst_busy", md_busy, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);

    // decode sweep
    for (int i = 0; i < 20; i++) dec(2'b10, sweep[i]);
    for (int i = 0; i < 4; i++) dec(2'(i), 6'b000000);
    dec(2'b10, 6'b010000); chk("dec_mfhi_oper", ALUoper, 4'd15); chk("dec_mfhi_hilo", hilo_rd, 2'b01);
    dec(2'b10, 6'b000011); chk("dec_sra", ALUoper, 4'd10);
    dec(2'b10, 6'b111111); chk("dec_undef", ALUoper, 4'd15);
    dec(2'b01, 6'b100100); chk("dec_aluop01", ALUoper, 4'd6);
    dec(2'b11, 6'b000000); chk("dec_aluop11", ALUoper, 4'd7);
    dec(2'b10, 6'b101010); chk("dec_legacy_slt", ALUoper, 4'd7);
    dec(2'b10, 6'b011010); chk("dec_div_mdop", md_op, 1'b1); chk("dec_div_oper", ALUoper, 4'd15);

    // multu with timing
    dec(2'b10, 6'b011001);
    run_md(32'hFFFFFFFF, 32'h2, e, bc);
    chk("multu_edges", 64'(e), 64'd34);
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    dec(2'b10, 6'b011000);
    run_md(32'hFFFFFFF9, 32'h3, e, bc);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);

    dec(2'b10, 6'b011010);
    run_md(32'hFFFFFFF9, 32'h2, e, bc);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    dec(2'b10, 6'b011011);
    run_md(32'd100, 32'd7, e, bc);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    // preload hi=5, lo=9, then divide by zero
    run_md(32'd68, 32'd7, e, bc);
    dec(2'b10, 6'b011010);
    run_md(32'd1234, 32'd0, e, bc);
    chk("dz_edges", 64'(e), 64'd2);
    chk("dz_flag", div_by_zero, 1'b1);
    chk("dz_hi", hi, 32'd5);
    chk("dz_lo", lo, 32'd9);

    run_md(32'h80000000, 32'hFFFFFFFF, e, bc);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h0);
    chk("ovf_flag", div_by_zero, 1'b0);

    // md_start while busy is ignored
    dec(2'b10, 6'b011001);
    src_a = 32'd3; src_b = 32'd4; md_start = 1'b1;
    @(negedge clk); md_start = 1'b0;
    repeat (4) @(negedge clk);
    src_a = 32'd99; src_b = 32'd99; md_start = 1'b1;
    wait_done(60, e, bc);
    chk("busy_start_lo", lo, 32'd12);

    // back-to-back start in the md_done cycle
    src_a = 32'd5; src_b = 32'd5; md_start = 1'b1;
    wait_done(60, e, bc);
    chk("b2b_edges", 64'(e), 64'd34);
    chk("b2b_lo", lo, 32'd25);

    // md_start with md_op=0 is ignored
    dec(2'b00, 6'b011000);
    src_a = 32'd2; src_b = 32'd2; md_start = 1'b1;
    @(negedge clk); md_start = 1'b0;
    chk("nomd_busy", md_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("nomd_lo", lo, 32'd25);

    // reset mid-CALC
    dec(2'b10, 6'b011000);
    src_a = 32'd7; src_b = 32'd9; md_start = 1'b1;
    @(negedge clk); md_start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", md_busy, 1'b0);
    chk("mrst_hi", hi, 32'h0);
    chk("mrst_lo", lo, 32'h0);
    chk("mrst_ALUoper", ALUoper, 4'd2);
    repeat (40) @(negedge clk);
    chk("mrst_no_done_lo", lo, 32'h0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) Func = {4'b0110, 2'($urandom_range(0, 3))};
      else Func = 6'($urandom);
      dec(2'b10, Func);
      src_a = pick();
      src_b = ($urandom_range(0, 5) == 0) ? 32'h0 : pick();
      md_start = 1'b1;
      for (int c = 0; c < 45; c++) begin
        @(negedge clk);
        md_start = ($urandom_range(0, 15) == 0);
        dec_en   = ($urandom_range(0, 7) == 0);
        ALUop    = 2'($urandom);
        Func     = 6'($urandom);
        src_a    = pick();
        src_b    = pick();
        if (md_done) break;
      end
      md_start = 1'b0;
      dec_en   = 1'b0;
    end
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
